// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sequencing one APB transfer at a time from NUM_REQ requesters.
// Grant to req_done is 4 cycles plus slave wait states; unmapped addresses finish in 1 cycle.
module apb_req_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
    parameter int          NUM_SLOTS = 11,
    localparam int         GNT_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [31:0]             req_rdata,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_err,
    output logic                    busy,
    output logic [GNT_W-1:0]        grant_id,
    output logic                    m_transfer,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic                    m_write,
    input  logic                    m_ready,
    input  logic [31:0]             m_rdata
);

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_SETUP,
        ARB_WAIT,
        ARB_DONE,
        ARB_ERR
    } state_t;

    localparam logic [4:0] SLOT_LIM = 5'(NUM_SLOTS);

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   ptr_q, ptr_d;
    logic [GNT_W-1:0]   grant_id_q, grant_id_d;
    logic [31:0]        m_addr_q, m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic               m_write_q, m_write_d;
    logic               m_transfer_q, m_transfer_d;
    logic [31:0]        req_rdata_q, req_rdata_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic [NUM_REQ-1:0] req_err_q, req_err_d;
    logic               busy_q, busy_d;

    logic               win_vld;
    logic [GNT_W-1:0]   win_idx;
    logic               win_write;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic               win_addr_ok;
    int                 scan_idx;

    // Scan starts just after the last winner so the previous grantee has lowest priority.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_vld && req[scan_idx]) begin
                win_vld   = 1'b1;
                win_idx   = GNT_W'(scan_idx);
                win_write = req_write[scan_idx];
                win_addr  = req_addr[32*scan_idx +: 32];
                win_wdata = req_wdata[32*scan_idx +: 32];
            end
        end
    end

    assign win_addr_ok = (win_addr[31:16] == ADDR_BASE[31:16]) &&
                         ({1'b0, win_addr[15:12]} < SLOT_LIM);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_write_d    = m_write_q;
        req_rdata_d  = req_rdata_q;
        m_transfer_d = 1'b0;
        req_done_d   = '0;
        req_err_d    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    ptr_d      = win_idx;
                    grant_id_d = win_idx;
                    m_addr_d   = win_addr;
                    m_wdata_d  = win_wdata;
                    m_write_d  = win_write;
                    if (win_addr_ok) begin
                        state_d      = ARB_ISSUE;
                        m_transfer_d = 1'b1;
                    end else begin
                        state_d             = ARB_ERR;
                        req_done_d[win_idx] = 1'b1;
                        req_err_d[win_idx]  = 1'b1;
                        req_rdata_d         = '0;
                    end
                end
            end
            ARB_ISSUE: state_d = ARB_SETUP;
            // m_ready is only meaningful once the master is in ACCESS.
            ARB_SETUP: state_d = ARB_WAIT;
            ARB_WAIT: begin
                if (m_ready) begin
                    state_d                = ARB_DONE;
                    req_rdata_d            = m_rdata;
                    req_done_d[grant_id_q] = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            ARB_ERR:  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= GNT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_write_q    <= 1'b0;
            m_transfer_q <= 1'b0;
            req_rdata_q  <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_write_q    <= m_write_d;
            m_transfer_q <= m_transfer_d;
            req_rdata_q  <= req_rdata_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_rdata  = req_rdata_q;
    assign req_done   = req_done_q;
    assign req_err    = req_err_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign m_transfer = m_transfer_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign m_write    = m_write_q;

endmodule
